// File: rtl/bcd_scan_decoder_if.sv
// Bus between the BCD arithmetic path (master) and the scan decoder (slave).
interface bcd_scan_decoder_if #(
  parameter int unsigned NUM_DIGITS = 4,
  parameter int unsigned ERR_CNT_W  = 8
) ();

  localparam int unsigned BCD_W = 4 * NUM_DIGITS;

  logic                  load;
  logic [BCD_W-1:0]      bcd_in;
  logic                  err_clr;
  logic [9:0]            y;
  logic [NUM_DIGITS-1:0] dig_sel;
  logic                  invalid;
  logic                  frame_done;
  logic [ERR_CNT_W-1:0]  err_cnt;

  // Producer of BCD words, consumer of the scanned display outputs.
  modport master (
    output load, bcd_in, err_clr,
    input  y, dig_sel, invalid, frame_done, err_cnt
  );

  // The scan decoder itself.
  modport slave (
    input  load, bcd_in, err_clr,
    output y, dig_sel, invalid, frame_done, err_cnt
  );

endinterface

// File: rtl/bcd_scan_decoder.sv
// Time-multiplexed BCD-to-decimal decoder: scans one digit of a held BCD word at a
// time, each for SCAN_DIV cycles, with one-hot decimal and digit-select outputs.
// Non-BCD codes blank the output, raise invalid and bump a saturating error counter.
module bcd_scan_decoder #(
  parameter int unsigned NUM_DIGITS = 4,
  parameter int unsigned SCAN_DIV   = 4,
  parameter int unsigned ERR_CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  bcd_scan_decoder_if.slave bus
);

  localparam int unsigned BCD_W = 4 * NUM_DIGITS;
  localparam int unsigned DIG_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int unsigned DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned SH_W  = DIG_W + 2;

  localparam logic [DIG_W-1:0] LAST_DIG = DIG_W'(NUM_DIGITS - 1);
  localparam logic [DIV_W-1:0] LAST_DIV = DIV_W'(SCAN_DIV - 1);

  typedef enum logic {
    IDLE,
    SCAN
  } state_e;

  state_e                state_q, state_d;
  logic [DIG_W-1:0]      digit_q, digit_d;
  logic [DIV_W-1:0]      div_q, div_d;
  logic [BCD_W-1:0]      active_q, active_d;
  logic [BCD_W-1:0]      shadow_q, shadow_d;
  logic                  pending_q, pending_d;
  logic [9:0]            y_q, y_d;
  logic [NUM_DIGITS-1:0] dig_sel_q, dig_sel_d;
  logic                  invalid_q, invalid_d;
  logic                  frame_done_q, frame_done_d;
  logic [ERR_CNT_W-1:0]  err_cnt_q, err_cnt_d;

  logic                  frame_end_c;
  logic [3:0]            cur_digit_c;

  // One-hot decimal decode; non-BCD codes decode to all zeros.
  function automatic logic [9:0] decode(input logic [3:0] d);
    logic [9:0] r;
    r = '0;
    if (d <= 4'd9) begin
      r = 10'b1 << d;
    end
    return r;
  endfunction

  // State register and all registered outputs; synchronous reset has priority.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      digit_q      <= '0;
      div_q        <= '0;
      active_q     <= '0;
      shadow_q     <= '0;
      pending_q    <= 1'b0;
      y_q          <= '0;
      dig_sel_q    <= '0;
      invalid_q    <= 1'b0;
      frame_done_q <= 1'b0;
      err_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      digit_q      <= digit_d;
      div_q        <= div_d;
      active_q     <= active_d;
      shadow_q     <= shadow_d;
      pending_q    <= pending_d;
      y_q          <= y_d;
      dig_sel_q    <= dig_sel_d;
      invalid_q    <= invalid_d;
      frame_done_q <= frame_done_d;
      err_cnt_q    <= err_cnt_d;
    end
  end

  // Next-state: scan counters, frame-aligned word swap, error counter, and the
  // outputs decoded from the next state so they line up with it when registered.
  always_comb begin
    state_d      = state_q;
    digit_d      = digit_q;
    div_d        = div_q;
    active_d     = active_q;
    shadow_d     = shadow_q;
    pending_d    = pending_q;
    err_cnt_d    = err_cnt_q;
    y_d          = '0;
    dig_sel_d    = '0;
    invalid_d    = 1'b0;
    frame_done_d = 1'b0;
    cur_digit_c  = '0;

    frame_end_c = (state_q == SCAN) && (digit_q == LAST_DIG) && (div_q == LAST_DIV);

    case (state_q)
      IDLE: begin
        if (bus.load) begin
          state_d   = SCAN;
          active_d  = bus.bcd_in;
          digit_d   = '0;
          div_d     = '0;
          pending_d = 1'b0;
        end
      end
      SCAN: begin
        if (div_q == LAST_DIV) begin
          div_d   = '0;
          digit_d = (digit_q == LAST_DIG) ? '0 : DIG_W'(digit_q + DIG_W'(1));
        end else begin
          div_d = DIV_W'(div_q + DIV_W'(1));
        end

        // Words only change at the frame wrap so a frame is never torn.
        if (frame_end_c) begin
          if (bus.load) begin
            active_d = bus.bcd_in;
          end else if (pending_q) begin
            active_d = shadow_q;
          end
          pending_d = 1'b0;
        end else if (bus.load) begin
          shadow_d  = bus.bcd_in;
          pending_d = 1'b1;
        end

        // Count each invalid slot once, in its first cycle, without wrapping.
        if (invalid_q && (div_q == '0) && (err_cnt_q != '1)) begin
          err_cnt_d = ERR_CNT_W'(err_cnt_q + ERR_CNT_W'(1));
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (bus.err_clr) begin
      err_cnt_d = '0;
    end

    if (state_d == SCAN) begin
      cur_digit_c  = 4'(active_d >> {digit_d, 2'b00});
      y_d          = decode(cur_digit_c);
      invalid_d    = (cur_digit_c > 4'd9);
      dig_sel_d    = NUM_DIGITS'(1) << digit_d;
      frame_done_d = (digit_d == LAST_DIG) && (div_d == LAST_DIV);
    end
  end

  assign bus.y          = y_q;
  assign bus.dig_sel    = dig_sel_q;
  assign bus.invalid    = invalid_q;
  assign bus.frame_done = frame_done_q;
  assign bus.err_cnt    = err_cnt_q;

endmodule
